pong_match: RTL and testbench

Parametrised match engine for the LED-matrix pong game: owns both paddles, the ball, scoring and the serve/play/game-over sequence. It replaces the free-running ball and paddle instances in the top level. It consumes the per-player rotary-encoder step values and produces the ball coordinates and paddle bitmaps for the screen driver. It adds scores and a win condition on top of the ball and paddle behaviour.

---
 rtl/pong_match.sv | 215 +++++++++++++++++++++
 tb/tb_pong_match.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pong_match.sv
// rtl/pong_match.sv - pong match engine: paddles, ball, scoring and serve/play/over sequencing
module pong_match #(
  parameter int COLS        = 16,
  parameter int ROWS        = 16,
  parameter int PADDLE_LEN  = 3,
  parameter int WIN_SCORE   = 9,
  parameter int TICK_DIV    = 6000,
  parameter int BALL_DIV    = 20,
  parameter int SERVE_TICKS = 500,
  localparam int XW = $clog2(COLS),
  localparam int YW = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic signed [1:0] p1_step,
  input  logic signed [1:0] p2_step,
  input  logic              start,
  output logic [XW-1:0]     ball_x,
  output logic [YW-1:0]     ball_y,
  output logic [ROWS-1:0]   lpaddle,
  output logic [ROWS-1:0]   rpaddle,
  output logic [3:0]        score1,
  output logic [3:0]        score2,
  output logic [1:0]        state,
  output logic              game_over
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BALL_DIV > 1) ? $clog2(BALL_DIV) : 1;
  localparam int SW = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BALL_LAST  = BW'(BALL_DIV - 1);
  localparam logic [SW-1:0] SERVE_LAST = SW'(SERVE_TICKS - 1);
  localparam logic [XW-1:0] X_MID      = XW'(COLS / 2);
  localparam logic [XW-1:0] X_LAST     = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_MID      = YW'(ROWS / 2);
  localparam logic [YW-1:0] Y_LAST     = YW'(ROWS - 1);
  localparam logic [YW-1:0] POS_MID    = YW'((ROWS - PADDLE_LEN) / 2);
  localparam logic [YW-1:0] POS_MAX    = YW'(ROWS - PADDLE_LEN);
  localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SERVE = 2'd1,
    S_PLAY  = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic [SW-1:0]     serve_cnt_q, serve_cnt_d;
  logic [BW-1:0]     bdiv_q, bdiv_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic              dx_neg_q, dx_neg_d, dy_neg_q, dy_neg_d;
  logic [YW-1:0]     lpos_q, lpos_d, rpos_q, rpos_d;
  logic [ROWS-1:0]   lpaddle_q, lpaddle_d, rpaddle_q, rpaddle_d;
  logic [3:0]        score1_q, score1_d, score2_q, score2_d;
  logic              game_over_q, game_over_d;

  logic              tick, at_left, at_right, hit, ny_dy_neg;
  logic [XW-1:0]     nx;
  logic [YW-1:0]     ny;

  function automatic logic [YW-1:0] paddle_move(input logic [YW-1:0] pos, input logic signed [1:0] step);
    logic [YW-1:0] r;
    r = pos;
    if (step == 2'sd1 && pos != POS_MAX) r = pos + YW'(1);
    else if (step == -2'sd1 && pos != '0) r = pos - YW'(1);
    return r;
  endfunction

  function automatic logic [ROWS-1:0] paddle_map(input logic [YW-1:0] pos);
    logic [ROWS-1:0] m;
    m = '0;
    for (int i = 0; i < ROWS; i++)
      if (i >= int'(pos) && i < int'(pos) + PADDLE_LEN) m[i] = 1'b1;
    return m;
  endfunction

  always_comb begin
    tick        = (tick_cnt_q == TICK_LAST);
    tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
    lpos_d      = paddle_move(lpos_q, p1_step);
    rpos_d      = paddle_move(rpos_q, p2_step);
    lpaddle_d   = paddle_map(lpos_d);
    rpaddle_d   = paddle_map(rpos_d);
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    bdiv_d      = bdiv_q;
    x_d         = x_q;
    y_d         = y_q;
    dx_neg_d    = dx_neg_q;
    dy_neg_d    = dy_neg_q;
    score1_d    = score1_q;
    score2_d    = score2_q;

    // Candidate next row, reflecting off the top/bottom wall before leaving the field
    if (dy_neg_q) begin
      ny_dy_neg = (y_q != '0);
      ny        = (y_q == '0) ? y_q + YW'(1) : y_q - YW'(1);
    end else begin
      ny_dy_neg = (y_q == Y_LAST);
      ny        = (y_q == Y_LAST) ? y_q - YW'(1) : y_q + YW'(1);
    end
    nx       = dx_neg_q ? x_q - XW'(1) : x_q + XW'(1);
    at_left  = (nx == '0);
    at_right = (nx == X_LAST);
    hit      = at_left ? lpaddle_q[ny] : rpaddle_q[ny];

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d     = S_SERVE;
          serve_cnt_d = '0;
          score1_d    = '0;
          score2_d    = '0;
          dx_neg_d    = 1'b0;
          x_d         = X_MID;
          y_d         = Y_MID;
        end
      end
      S_SERVE: begin
        if (tick) begin
          if (serve_cnt_q == SERVE_LAST) begin
            state_d = S_PLAY;
            bdiv_d  = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + SW'(1);
          end
        end
      end
      S_PLAY: begin
        if (tick && bdiv_q != BALL_LAST) begin
          bdiv_d = bdiv_q + BW'(1);
        end else if (tick) begin
          bdiv_d = '0;
          if (!at_left && !at_right) begin
            x_d      = nx;
            y_d      = ny;
            dy_neg_d = ny_dy_neg;
          end else if (hit) begin
            dx_neg_d = !dx_neg_q;
            y_d      = ny;
            dy_neg_d = ny_dy_neg;
          end else begin
            if (at_right) score1_d = score1_q + 4'd1;
            else          score2_d = score2_q + 4'd1;
            // On a winning point the ball is left where it was before the step
            if ((at_right ? score1_d : score2_d) == WIN) begin
              state_d = S_OVER;
            end else begin
              state_d     = S_SERVE;
              serve_cnt_d = '0;
              x_d         = X_MID;
              y_d         = Y_MID;
              dy_neg_d    = 1'b0;
              dx_neg_d    = at_left;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    game_over_d = (state_d == S_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= '0;
      serve_cnt_q <= '0;
      bdiv_q      <= '0;
      x_q         <= X_MID;
      y_q         <= Y_MID;
      dx_neg_q    <= 1'b0;
      dy_neg_q    <= 1'b0;
      lpos_q      <= POS_MID;
      rpos_q      <= POS_MID;
      lpaddle_q   <= paddle_map(POS_MID);
      rpaddle_q   <= paddle_map(POS_MID);
      score1_q    <= '0;
      score2_q    <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      serve_cnt_q <= serve_cnt_d;
      bdiv_q      <= bdiv_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dx_neg_q    <= dx_neg_d;
      dy_neg_q    <= dy_neg_d;
      lpos_q      <= lpos_d;
      rpos_q      <= rpos_d;
      lpaddle_q   <= lpaddle_d;
      rpaddle_q   <= rpaddle_d;
      score1_q    <= score1_d;
      score2_q    <= score2_d;
      game_over_q <= game_over_d;
    end
  end

  assign ball_x    = x_q;
  assign ball_y    = y_q;
  assign lpaddle   = lpaddle_q;
  assign rpaddle   = rpaddle_q;
  assign score1    = score1_q;
  assign score2    = score2_q;
  assign state     = state_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_pong_match.sv
// tb/tb_pong_match.sv - self-checking bench for pong_match: directed scenarios plus random play against a reference model
module tb_pong_match;
  localparam int C = 8, R = 8, PL = 3, WS = 2, TD = 2, BD = 1, ST = 2;

  logic              clk = 1'b0;
  logic              reset_i = 1'b1;
  logic              start_i = 1'b0;
  logic signed [1:0] p1_i = 2'sd0;
  logic signed [1:0] p2_i = 2'sd0;
  logic [2:0]        ball_x, ball_y;
  logic [7:0]        lpaddle, rpaddle;
  logic [3:0]        score1, score2;
  logic [1:0]        state;
  logic              game_over;

  int errors = 0;
  int checks = 0;

  int m_state, m_x, m_y, m_dx, m_dy, m_lpos, m_rpos, m_s1, m_s2, m_tick, m_serve, m_bdiv;

  pong_match #(
    .COLS(C), .ROWS(R), .PADDLE_LEN(PL), .WIN_SCORE(WS),
    .TICK_DIV(TD), .BALL_DIV(BD), .SERVE_TICKS(ST)
  ) dut (
    .clk(clk), .reset(reset_i), .p1_step(p1_i), .p2_step(p2_i), .start(start_i),
    .ball_x(ball_x), .ball_y(ball_y), .lpaddle(lpaddle), .rpaddle(rpaddle),
    .score1(score1), .score2(score2), .state(state), .game_over(game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [R-1:0] pmap(input int pos);
    logic [R-1:0] m;
    m = '0;
    for (int i = 0; i < PL; i++) m[pos+i] = 1'b1;
    return m;
  endfunction

  function automatic int pmove(input int pos, input logic signed [1:0] step);
    int s;
    s = int'(step);
    if (s == -2) s = 0;
    pos = pos + s;
    if (pos < 0) pos = 0;
    if (pos > R - PL) pos = R - PL;
    return pos;
  endfunction

  // Reference model: advance one clock edge using the inputs the DUT just sampled
  task automatic model_edge();
    bit tick;
    logic [R-1:0] lm, rm, map;
    int nx, ny, ndy;
    if (reset_i) begin
      m_state = 0; m_x = C / 2; m_y = R / 2; m_dx = 1; m_dy = 1;
      m_lpos = (R - PL) / 2; m_rpos = (R - PL) / 2;
      m_s1 = 0; m_s2 = 0; m_tick = 0; m_serve = 0; m_bdiv = 0;
      return;
    end
    tick = (m_tick == TD - 1);
    m_tick = (m_tick + 1) % TD;
    lm = pmap(m_lpos);
    rm = pmap(m_rpos);
    m_lpos = pmove(m_lpos, p1_i);
    m_rpos = pmove(m_rpos, p2_i);
    case (m_state)
      0, 3: if (start_i) begin
        m_state = 1; m_serve = 0; m_s1 = 0; m_s2 = 0; m_dx = 1; m_x = C / 2; m_y = R / 2;
      end
      1: if (tick) begin
        m_serve++;
        if (m_serve == ST) begin m_state = 2; m_bdiv = 0; end
      end
      2: if (tick) begin
        m_bdiv++;
        if (m_bdiv == BD) begin
          m_bdiv = 0;
          ny = m_y + m_dy; ndy = m_dy;
          if (ny < 0 || ny > R - 1) begin ndy = -m_dy; ny = m_y - m_dy; end
          nx = m_x + m_dx;
          if (nx > 0 && nx < C - 1) begin
            m_x = nx; m_y = ny; m_dy = ndy;
          end else begin
            map = (nx == 0) ? lm : rm;
            if (map[ny]) begin
              m_dx = -m_dx; m_y = ny; m_dy = ndy;
            end else begin
              if (nx == 0) m_s2++; else m_s1++;
              if (m_s1 == WS || m_s2 == WS) m_state = 3;
              else begin
                m_state = 1; m_serve = 0; m_x = C / 2; m_y = R / 2; m_dy = 1;
                m_dx = (nx == 0) ? -1 : 1;
              end
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_move(input int limit, output int n);
    logic [15:0] snap;
    snap = {ball_x, ball_y, state, score1, score2};
    n = 0;
    while ({ball_x, ball_y, state, score1, score2} == snap && n < limit) begin
      cycle();
      n++;
    end
    if ({ball_x, ball_y, state, score1, score2} == snap) begin
      checks++; errors++;
      $display("FAIL wait_move: no ball/state change within %0d cycles", limit);
    end
  endtask

  task automatic wait_state(input int target, input int limit, output int n);
    n = 0;
    while (int'(state) != target && n < limit) begin
      cycle();
      n++;
    end
    if (int'(state) != target) begin
      checks++; errors++;
      $display("FAIL wait_state: state %0d, required %0d within %0d cycles", state, target, limit);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    cycle();
    cycle();
    reset_i = 1'b0;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if ({ball_x, ball_y} !== {3'd4, 3'd4}) begin errors++; $display("FAIL reset_ball: got (%0d,%0d) expected (4,4)", ball_x, ball_y); end
    checks++; if (lpaddle !== 8'h1C) begin errors++; $display("FAIL reset_lpaddle: got %h expected 1c", lpaddle); end
    checks++; if (rpaddle !== 8'h1C) begin errors++; $display("FAIL reset_rpaddle: got %h expected 1c", rpaddle); end
    checks++; if ({score1, score2} !== 8'h00) begin errors++; $display("FAIL reset_scores: got %0d/%0d expected 0/0", score1, score2); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
  endtask

  task automatic test_paddle_saturation();
    p1_i = -2'sd1;
    repeat (10) cycle();
    checks++; if (lpaddle !== 8'h07) begin errors++; $display("FAIL sat_top: got %h expected 07", lpaddle); end
    p1_i = -2'sd2;
    repeat (3) cycle();
    checks++; if (lpaddle !== 8'h07) begin errors++; $display("FAIL step_minus2: got %h expected 07", lpaddle); end
    p1_i = 2'sd1;
    cycle();
    checks++; if (lpaddle !== 8'h0E) begin errors++; $display("FAIL step_latency: got %h expected 0e", lpaddle); end
    repeat (9) cycle();
    checks++; if (lpaddle !== 8'hE0) begin errors++; $display("FAIL sat_bottom: got %h expected e0", lpaddle); end
    checks++; if (rpaddle !== 8'h1C) begin errors++; $display("FAIL rpaddle_still: got %h expected 1c", rpaddle); end
    p1_i = -2'sd1;
    repeat (3) cycle();
    p1_i = 2'sd0;
    checks++; if (lpaddle !== 8'h1C) begin errors++; $display("FAIL lpaddle_centre: got %h expected 1c", lpaddle); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", state); end
  endtask

  task automatic test_serve_miss();
    int n;
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL start_to_serve: got %0d expected 1", state); end
    wait_state(2, 20, n);
    checks++; if (n < 3 || n > 4) begin errors++; $display("FAIL serve_length: got %0d cycles expected 3..4", n); end
    checks++; if ({ball_x, ball_y} !== {3'd4, 3'd4}) begin errors++; $display("FAIL serve_centre: got (%0d,%0d) expected (4,4)", ball_x, ball_y); end
    wait_move(10, n);
    checks++; if ({ball_x, ball_y} !== {3'd5, 3'd5} || n != 2) begin errors++; $display("FAIL step1: got (%0d,%0d) after %0d expected (5,5) after 2", ball_x, ball_y, n); end
    wait_move(10, n);
    checks++; if ({ball_x, ball_y} !== {3'd6, 3'd6} || n != 2) begin errors++; $display("FAIL step2: got (%0d,%0d) after %0d expected (6,6) after 2", ball_x, ball_y, n); end
    wait_move(10, n);
    checks++; if ({state, score1, score2} !== {2'd1, 4'd1, 4'd0}) begin errors++; $display("FAIL miss_score: got state %0d scores %0d/%0d expected 1 1/0", state, score1, score2); end
    checks++; if ({ball_x, ball_y} !== {3'd4, 3'd4}) begin errors++; $display("FAIL miss_recentre: got (%0d,%0d) expected (4,4)", ball_x, ball_y); end
  endtask

  task automatic test_deflect_bounce();
    int n;
    p2_i = 2'sd1;
    repeat (3) cycle();
    p2_i = 2'sd0;
    checks++; if (rpaddle !== 8'hE0) begin errors++; $display("FAIL rpaddle_low: got %h expected e0", rpaddle); end
    wait_state(2, 20, n);
    wait_move(10, n);
    checks++; if ({ball_x, ball_y} !== {3'd5, 3'd5}) begin errors++; $display("FAIL reserve_dx: got (%0d,%0d) expected (5,5)", ball_x, ball_y); end
    wait_move(10, n);
    wait_move(10, n);
    checks++; if ({ball_x, ball_y, state} !== {3'd6, 3'd7, 2'd2}) begin errors++; $display("FAIL deflect: got (%0d,%0d) state %0d expected (6,7) state 2", ball_x, ball_y, state); end
    wait_move(10, n);
    checks++; if ({ball_x, ball_y} !== {3'd5, 3'd6}) begin errors++; $display("FAIL wall_bounce: got (%0d,%0d) expected (5,6)", ball_x, ball_y); end
  endtask

  task automatic test_win();
    int n;
    p1_i = -2'sd1;
    p2_i = -2'sd1;
    repeat (10) cycle();
    p1_i = 2'sd0;
    p2_i = 2'sd0;
    wait_state(3, 100, n);
    checks++; if ({state, game_over} !== {2'd3, 1'b1}) begin errors++; $display("FAIL win_state: got %0d/%b expected 3/1", state, game_over); end
    checks++; if ({score1, score2} !== {4'd2, 4'd0}) begin errors++; $display("FAIL win_score: got %0d/%0d expected 2/0", score1, score2); end
    checks++; if ({ball_x, ball_y} !== {3'd6, 3'd4}) begin errors++; $display("FAIL win_ball: got (%0d,%0d) expected (6,4)", ball_x, ball_y); end
    p1_i = 2'sd1;
    repeat (4) cycle();
    p1_i = 2'sd0;
    checks++; if ({ball_x, ball_y, state} !== {3'd6, 3'd4, 2'd3}) begin errors++; $display("FAIL over_frozen: got (%0d,%0d) state %0d expected (6,4) state 3", ball_x, ball_y, state); end
    checks++; if (lpaddle !== 8'h70) begin errors++; $display("FAIL over_paddle: got %h expected 70", lpaddle); end
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    checks++; if ({state, score1, game_over} !== {2'd1, 4'd0, 1'b0}) begin errors++; $display("FAIL restart: got state %0d score1 %0d go %b expected 1 0 0", state, score1, game_over); end
    checks++; if ({ball_x, ball_y} !== {3'd4, 3'd4}) begin errors++; $display("FAIL restart_ball: got (%0d,%0d) expected (4,4)", ball_x, ball_y); end
  endtask

  task automatic test_reset_mid_play();
    int n;
    wait_state(2, 20, n);
    start_i = 1'b1;
    cycle();
    start_i = 1'b0;
    checks++; if ({state, score1, score2} !== {2'd2, 4'd0, 4'd0}) begin errors++; $display("FAIL start_ignored: got state %0d scores %0d/%0d expected 2 0/0", state, score1, score2); end
    wait_move(10, n);
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    checks++; if ({state, ball_x, ball_y} !== {2'd0, 3'd4, 3'd4}) begin errors++; $display("FAIL reset_mid_play: got state %0d (%0d,%0d) expected 0 (4,4)", state, ball_x, ball_y); end
    checks++; if ({lpaddle, rpaddle} !== 16'h1C1C) begin errors++; $display("FAIL reset_paddles: got %h/%h expected 1c/1c", lpaddle, rpaddle); end
  endtask

  task automatic test_random();
    reset_i = 1'b1;
    cycle();
    reset_i = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      p1_i    = 2'($urandom_range(0, 3));
      p2_i    = 2'($urandom_range(0, 3));
      start_i = ($urandom_range(0, 15) == 0);
      reset_i = ($urandom_range(0, 399) == 0);
      cycle();
      checks++; if (state !== 2'(m_state)) begin errors++; $display("FAIL rnd_state @%0d: got %0d expected %0d", i, state, m_state); end
      checks++; if (ball_x !== 3'(m_x)) begin errors++; $display("FAIL rnd_ball_x @%0d: got %0d expected %0d", i, ball_x, m_x); end
      checks++; if (ball_y !== 3'(m_y)) begin errors++; $display("FAIL rnd_ball_y @%0d: got %0d expected %0d", i, ball_y, m_y); end
      checks++; if (lpaddle !== pmap(m_lpos)) begin errors++; $display("FAIL rnd_lpaddle @%0d: got %h expected %h", i, lpaddle, pmap(m_lpos)); end
      checks++; if (rpaddle !== pmap(m_rpos)) begin errors++; $display("FAIL rnd_rpaddle @%0d: got %h expected %h", i, rpaddle, pmap(m_rpos)); end
      checks++; if (score1 !== 4'(m_s1)) begin errors++; $display("FAIL rnd_score1 @%0d: got %0d expected %0d", i, score1, m_s1); end
      checks++; if (score2 !== 4'(m_s2)) begin errors++; $display("FAIL rnd_score2 @%0d: got %0d expected %0d", i, score2, m_s2); end
      checks++; if (game_over !== (m_state == 3)) begin errors++; $display("FAIL rnd_game_over @%0d: got %b expected %b", i, game_over, m_state == 3); end
    end
    reset_i = 1'b0;
    start_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_paddle_saturation();
    test_serve_miss();
    test_deflect_bounce();
    test_win();
    test_reset_mid_play();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
